pc_gen: RTL

Registered program-counter generator for the fetch stage: holds the IF PC, computes the next PC from sequential, branch, jump, register-jump, exception and eret sources, and emits the IF/ID/EX flush strobes. Unlike the old combinational next-PC logic, it owns the PC register. It buffers a control-flow redirect that resolves while fetch is stalled, and applies it when fetch resumes. It sits between the ID-stage branch/jump decode, the MEM-stage exception logic, and the instruction-fetch address port.

---
 rtl/pc_gen.sv | 123 ++++++++++++
 1 files changed

// File: rtl/pc_gen.sv
// Fetch-stage program-counter generator: owns the IF PC register, selects the next PC
// from sequential/branch/jump/register-jump/exception/eret sources, and drives flush strobes.
module pc_gen #(
  parameter logic [31:0] RESET_VEC = 32'hBFC0_0000,
  parameter logic [31:0] EXC_VEC   = 32'hBFC0_0380,
  parameter int unsigned ERET_ADJ  = 4
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        pc_wr,
  input  logic [1:0]  npc_op,
  input  logic [31:0] br_base,
  input  logic [25:0] imm,
  input  logic [31:0] ret_addr,
  input  logic [31:0] epc,
  input  logic        eret_flush,
  input  logic        ex,
  output logic [31:0] pc,
  output logic [31:0] npc,
  output logic        pend_valid,
  output logic        pc_adel,
  output logic        if_flush,
  output logic        id_flush,
  output logic        ex_flush
);

  localparam logic [31:0] ERET_ADJ_W = 32'(ERET_ADJ);

  logic [31:0] pc_r;
  logic        pend_valid_r;
  logic [31:0] pend_addr_r;
  logic [31:0] seq_pc_s;
  logic [31:0] target_s;
  logic [31:0] npc_s;
  logic        redirect_s;
  logic        trap_s;
  logic        pend_valid_nxt_s;
  logic [31:0] pend_addr_nxt_s;

  assign seq_pc_s   = pc_r + 32'd4;
  assign redirect_s = (npc_op != 2'b00);
  assign trap_s     = eret_flush || ex;

  // Redirect target decoded from the ID-stage control-flow op.
  always_comb begin
    target_s = seq_pc_s;
    case (npc_op)
      2'b01:   target_s = br_base + {{14{imm[15]}}, imm[15:0], 2'b00};
      2'b10:   target_s = {br_base[31:28], imm, 2'b00};
      2'b11:   target_s = ret_addr;
      default: target_s = seq_pc_s;
    endcase
  end

  // Next-PC priority select; eret beats exception, and both override a stall.
  always_comb begin
    npc_s = pc_r;
    if (eret_flush) begin
      npc_s = epc + ERET_ADJ_W;
    end else if (ex) begin
      npc_s = EXC_VEC;
    end else if (pc_wr && redirect_s) begin
      npc_s = target_s;
    end else if (pc_wr && pend_valid_r) begin
      npc_s = pend_addr_r;
    end else if (pc_wr) begin
      npc_s = seq_pc_s;
    end else begin
      npc_s = pc_r;
    end
  end

  // Pending-redirect bookkeeping: capture a redirect that resolves while fetch is stalled.
  always_comb begin
    pend_valid_nxt_s = pend_valid_r;
    pend_addr_nxt_s  = pend_addr_r;
    if (trap_s || pc_wr) begin
      pend_valid_nxt_s = 1'b0;
      pend_addr_nxt_s  = pend_addr_r;
    end else if (redirect_s) begin
      pend_valid_nxt_s = 1'b1;
      pend_addr_nxt_s  = target_s;
    end else begin
      pend_valid_nxt_s = pend_valid_r;
      pend_addr_nxt_s  = pend_addr_r;
    end
  end

  // State registers; reset discards any buffered redirect.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      pc_r         <= RESET_VEC;
      pend_valid_r <= 1'b0;
      pend_addr_r  <= 32'h0000_0000;
    end else begin
      pc_r         <= npc_s;
      pend_valid_r <= pend_valid_nxt_s;
      pend_addr_r  <= pend_addr_nxt_s;
    end
  end

  // Flush strobes: any taken redirect kills IF; traps kill IF/ID/EX.
  always_comb begin
    if_flush = 1'b0;
    id_flush = 1'b0;
    ex_flush = 1'b0;
    if (trap_s) begin
      if_flush = 1'b1;
      id_flush = 1'b1;
      ex_flush = 1'b1;
    end else if (pc_wr && (redirect_s || pend_valid_r)) begin
      if_flush = 1'b1;
    end else begin
      if_flush = 1'b0;
    end
  end

  assign pc         = pc_r;
  assign npc        = npc_s;
  assign pend_valid = pend_valid_r;
  assign pc_adel    = |pc_r[1:0];

endmodule
